regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Sequences the register file's single write port. Arbitrates between two writeback requesters, the ALU and the memory/load unit, and produces registered take_data/dr/dr_in for the register file. Keeps a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards against in-flight writebacks. Sits between the execute/memory stages and the 8x16 register file.

Parameters:
DATA_W, 16, writeback data width
NREG, 8, number of architectural registers
REG_AW, 3, register index width (log2 NREG)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
alu_valid  in  1  ALU writeback request
alu_dr  in  REG_AW  ALU destination index
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request granted this cycle
mem_valid  in  1  load writeback request
mem_dr  in  REG_AW  load destination index
mem_data  in  DATA_W  load data
mem_ready  out  1  load request granted this cycle
iss_valid  in  1  issue stage presents an instruction
iss_wr  in  1  instruction writes a destination
iss_dr  in  REG_AW  destination index
iss_sr1  in  REG_AW  source 1 index
iss_sr2  in  REG_AW  source 2 index
iss_stall  out  1  hold issue; instruction not accepted
rf_take_data  out  1  register file write enable
rf_dr  out  REG_AW  register file write index
rf_dr_in  out  DATA_W  register file write data
busy  out  NREG  scoreboard vector, bit r = write to Rr pending

Behaviour:
- Reset (async, rst=1): rf_take_data=0, rf_dr=0, rf_dr_in=0, busy=0, last-grant pointer=MEM. alu_ready=mem_ready=0 while rst=1. In-flight requests are dropped; requesters re-present after reset.
- Transfer = valid & ready at a rising edge. The write port never back-pressures, so at most one grant per cycle. A grant is issued whenever any valid is high.
- ready is combinational from the valids and the pointer. The loser sees ready=0 and must hold valid/dr/data stable until granted.
- Arbitration: one valid -> that requester granted. Both valid -> requester differs from last-grant pointer (round-robin). The pointer updates only on a grant.
- Latency: transfer at edge N -> rf_take_data=1 with rf_dr/rf_dr_in = granted dr/data during cycle N..N+1. The register file writes at edge N+1. No grant -> rf_take_data=0 next cycle; rf_dr/rf_dr_in hold their previous values.
- Scoreboard set: at an edge with iss_valid & iss_wr & !iss_stall, busy[iss_dr] <= 1.
- Scoreboard clear: at an edge with rf_take_data=1, busy[rf_dr] <= 0, coincident with the register file write.
- Simultaneous set and clear on different registers: both take effect. On the same register: set wins. This is unreachable while the WAW stall is active, but must be implemented.
- iss_stall = iss_valid & (busy[iss_sr1] | busy[iss_sr2] | (iss_wr & busy[iss_dr])). It is combinational from registered busy. There is no forwarding: the first issue cycle without stall is the cycle after the write edge.
- A writeback to a register whose busy bit is 0 is legal. It writes normally and leaves the scoreboard untouched.
- Two in-flight writes to one register cannot occur because of the WAW stall. The scoreboard is one bit per register, not a counter.

Optional Feature:
RR_ARB_EN: defined -> round-robin arbitration as above. Undefined -> fixed priority, MEM always wins a conflict; the pointer logic is removed and ALU waits until mem_valid=0. The scoreboard and latency are identical in both builds.

Decomposition:
- Package lc3b_rf_pkg holds: DATA_W, REG_AW, NREG constants; the requester id enum (REQ_ALU, REQ_MEM); the busy-vector typedef.
- One natural sub-module, rf_scoreboard: busy register, set/clear logic and the stall compare.
- The arbiter and the output register stay in the top.

Test Plan:
- Reset, then alu_valid=1, alu_dr=3, alu_data=16'h1234 for 1 cycle -> alu_ready=1; next cycle rf_take_data=1, rf_dr=3, rf_dr_in=16'h1234; following cycle rf_take_data=0.
- Both valid for 3 cycles, alu_dr=1, mem_dr=2, requesters drop valid after grant (RR_ARB_EN) -> ALU granted first, MEM second; rf_dr sequence 1,2. Without macro -> MEM first.
- Issue iss_wr=1, iss_dr=5, then iss_sr1=5 next cycle -> busy[5]=1, iss_stall=1 until the cycle after rf_take_data=1 with rf_dr=5.
- Issue iss_dr=4 while busy[4]=1 -> iss_stall=1 (WAW); busy unchanged.
- Writeback to R7 with busy=0 -> rf_take_data=1, busy stays 8'h00.
- Assert rst while busy=8'h0C and rf_take_data=1 -> immediately busy=0, rf_take_data=0, alu_ready=mem_ready=0 without a clock edge.

Source files
------------

// File: rtl/lc3b_rf_pkg.sv
// Shared constants and types for the register file writeback path.
// Holds the requester ids and the busy scoreboard vector type.
package lc3b_rf_pkg;
    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef logic [NREG-1:0] busy_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with RAW/WAW issue stall.
// Set and clear may land on one edge; set wins on the same register.
import lc3b_rf_pkg::*;

module rf_scoreboard (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_iss_valid,
    input  logic              i_iss_wr,
    input  logic [REG_AW-1:0] i_iss_dr,
    input  logic [REG_AW-1:0] i_iss_sr1,
    input  logic [REG_AW-1:0] i_iss_sr2,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_wb_dr,
    output busy_t             o_busy,
    output logic              o_stall
);
    busy_t r_busy;
    busy_t w_busy_nxt;
    logic  w_set;

    assign w_set = i_iss_valid & i_iss_wr & ~o_stall;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wb_en)
            w_busy_nxt[i_wb_dr] = 1'b0;
        if (w_set)
            w_busy_nxt[i_iss_dr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // No forwarding: stall reads only the registered vector.
    assign o_stall = i_iss_valid &
                     (r_busy[i_iss_sr1] |
                      r_busy[i_iss_sr2] |
                      (i_iss_wr & r_busy[i_iss_dr]));

    assign o_busy = r_busy;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto the single register file write port.
// RR_ARB_EN selects round-robin; otherwise MEM has fixed priority.
import lc3b_rf_pkg::*;

module regfile_wb_arbiter (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_dr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_dr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              iss_valid,
    input  logic              iss_wr,
    input  logic [REG_AW-1:0] iss_dr,
    input  logic [REG_AW-1:0] iss_sr1,
    input  logic [REG_AW-1:0] iss_sr2,
    output logic              iss_stall,
    output logic              rf_take_data,
    output logic [REG_AW-1:0] rf_dr,
    output logic [DATA_W-1:0] rf_dr_in,
    output busy_t             busy
);
    logic              w_gnt_alu;
    logic              w_gnt_mem;
    logic              r_take;
    logic [REG_AW-1:0] r_dr;
    logic [DATA_W-1:0] r_din;

`ifdef RR_ARB_EN
    req_e r_last;

    assign w_gnt_alu = alu_valid & (~mem_valid | (r_last == REQ_MEM));
    assign w_gnt_mem = mem_valid & ~w_gnt_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= REQ_MEM;
        else if (w_gnt_alu)
            r_last <= REQ_ALU;
        else if (w_gnt_mem)
            r_last <= REQ_MEM;
    end
`else
    assign w_gnt_mem = mem_valid;
    assign w_gnt_alu = alu_valid & ~mem_valid;
`endif

    // Grants are masked during reset so nothing transfers into it.
    assign alu_ready = w_gnt_alu & ~rst;
    assign mem_ready = w_gnt_mem & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_take <= 1'b0;
            r_dr   <= '0;
            r_din  <= '0;
        end else begin
            r_take <= w_gnt_alu | w_gnt_mem;
            if (w_gnt_mem) begin
                r_dr  <= mem_dr;
                r_din <= mem_data;
            end else if (w_gnt_alu) begin
                r_dr  <= alu_dr;
                r_din <= alu_data;
            end
        end
    end

    assign rf_take_data = r_take;
    assign rf_dr        = r_dr;
    assign rf_dr_in     = r_din;

    rf_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_iss_valid (iss_valid),
        .i_iss_wr    (iss_wr),
        .i_iss_dr    (iss_dr),
        .i_iss_sr1   (iss_sr1),
        .i_iss_sr2   (iss_sr2),
        .i_wb_en     (r_take),
        .i_wb_dr     (r_dr),
        .o_busy      (busy),
        .o_stall     (iss_stall)
    );
endmodule
